bcd_down_timer: RTL and testbench



---
 rtl/bcd_timer_pkg.sv | 21 ++
 rtl/bcd_down_timer_if.sv | 30 +++
 rtl/bcd_digit_down.sv | 35 +++
 rtl/bcd_down_timer.sv | 133 +++++++++++++
 tb/tb_bcd_down_timer.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/bcd_timer_pkg.sv
// Shared definitions for the BCD countdown timer.
//   BCD_W / BCD_MAX : width and largest legal value of one BCD decade
//   state_t         : timer FSM state encoding
//   sat_digit()     : clamps a non-BCD nibble (A..F) to 9
package bcd_timer_pkg;

    localparam int unsigned BCD_W   = 4;
    localparam logic [3:0]  BCD_MAX = 4'h9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic logic [BCD_W-1:0] sat_digit(input logic [BCD_W-1:0] d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/bcd_down_timer_if.sv
// Control/status bundle of the BCD countdown timer.
//   master : drives clear/load/load_val/start/pause, observes status
//   slave  : the timer itself; drives cnt/busy/paused/zero/done
interface bcd_down_timer_if
    import bcd_timer_pkg::*;
#(
    parameter int unsigned N_DIGITS = 2
);
    logic                        clear;
    logic                        load;
    logic [BCD_W*N_DIGITS-1:0]   load_val;
    logic                        start;
    logic                        pause;
    logic [BCD_W*N_DIGITS-1:0]   cnt;
    logic                        busy;
    logic                        paused;
    logic                        zero;
    logic                        done;

    modport master (
        output clear, load, load_val, start, pause,
        input  cnt, busy, paused, zero, done
    );

    modport slave (
        input  clear, load, load_val, start, pause,
        output cnt, busy, paused, zero, done
    );

endinterface

// File: rtl/bcd_digit_down.sv
// One BCD decade of a down-counter.
//   clk, rstn  : clock, async active-low reset
//   clr        : sync clear to 0 (highest priority)
//   ld, ld_val : sync load (ld_val must already be a legal BCD digit)
//   dec_in     : decrement request; 0 wraps to 9
//   digit      : registered digit value
//   borrow_out : decrement request passed to the next decade
module bcd_digit_down
    import bcd_timer_pkg::*;
(
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic             ld,
    input  logic [BCD_W-1:0] ld_val,
    input  logic             dec_in,
    output logic [BCD_W-1:0] digit,
    output logic             borrow_out
);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            digit <= '0;
        end else if (clr) begin
            digit <= '0;
        end else if (ld) begin
            digit <= ld_val;
        end else if (dec_in) begin
            digit <= (digit == '0) ? BCD_MAX : digit - BCD_W'(1);
        end
    end

    assign borrow_out = dec_in & (digit == '0);

endmodule

// File: rtl/bcd_down_timer.sv
// Loadable N-digit BCD countdown timer with prescaler and pause/resume.
//   clk, rstn : clock, async active-low reset
//   bus       : control (clear > load > start > pause) and status
//               (cnt, busy, paused, zero, done one-cycle pulse)
module bcd_down_timer
    import bcd_timer_pkg::*;
#(
    parameter int unsigned N_DIGITS = 2,
    parameter int unsigned TICK_DIV = 1
)(
    input  logic             clk,
    input  logic             rstn,
    bcd_down_timer_if.slave  bus
);

    localparam int unsigned CW = BCD_W * N_DIGITS;
    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

    state_t          state_q, state_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic            done_q, done_d;
    logic            busy_q, paused_q;
    logic [CW-1:0]   cnt;
    logic            digit_clr, digit_ld, count_en, tick;
    logic [N_DIGITS-1:0] dec_chain;
    logic            unused_borrow;

    assign tick = (presc_q == TICK_LAST);

    always_comb begin
        state_d   = state_q;
        presc_d   = presc_q;
        done_d    = 1'b0;
        digit_clr = 1'b0;
        digit_ld  = 1'b0;
        count_en  = 1'b0;
        if (bus.clear) begin
            digit_clr = 1'b1;
            presc_d   = '0;
            state_d   = ST_IDLE;
        end else if (bus.load) begin
            digit_ld = 1'b1;
            presc_d  = '0;
            state_d  = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        if (cnt == '0) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_RUN;
                            presc_d = '0;
                        end
                    end
                end
                ST_RUN: begin
                    // start overrides pause, so only a lone pause suspends
                    if (bus.pause && !bus.start) begin
                        state_d = ST_PAUSE;
                    end else begin
                        count_en = 1'b1;
                        if (tick) begin
                            presc_d = '0;
                            if (cnt == CW'(1)) begin
                                state_d = ST_DONE;
                                done_d  = 1'b1;
                            end
                        end else begin
                            presc_d = presc_q + PW'(1);
                        end
                    end
                end
                ST_PAUSE: begin
                    // prescaler is held, so the partial tick is preserved
                    if (bus.start) begin
                        state_d = ST_RUN;
                    end
                end
                ST_DONE: begin
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= ST_IDLE;
            presc_q  <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            paused_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            done_q   <= done_d;
            busy_q   <= (state_d == ST_RUN);
            paused_q <= (state_d == ST_PAUSE);
        end
    end

    assign dec_chain[0] = count_en & tick;

    for (genvar k = 0; k < N_DIGITS; k++) begin : g_digit
        logic borrow;
        bcd_digit_down u_digit (
            .clk        (clk),
            .rstn       (rstn),
            .clr        (digit_clr),
            .ld         (digit_ld),
            .ld_val     (sat_digit(bus.load_val[BCD_W*k +: BCD_W])),
            .dec_in     (dec_chain[k]),
            .digit      (cnt[BCD_W*k +: BCD_W]),
            .borrow_out (borrow)
        );
        if (k < N_DIGITS - 1) begin : g_chain
            assign dec_chain[k+1] = borrow;
        end else begin : g_top
            // RUN never decrements a zero count, so the top borrow stays low
            assign unused_borrow = borrow;
        end
    end

    assign bus.cnt    = cnt;
    assign bus.busy   = busy_q;
    assign bus.paused = paused_q;
    assign bus.zero   = (cnt == '0);
    assign bus.done   = done_q;

endmodule

// File: tb/tb_bcd_down_timer.sv
// Directed bench for bcd_down_timer: one instance with TICK_DIV=1, one with TICK_DIV=4.
module tb_bcd_down_timer;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    bcd_down_timer_if #(.N_DIGITS(2)) if1 ();
    bcd_down_timer_if #(.N_DIGITS(2)) if4 ();

    bcd_down_timer #(.N_DIGITS(2), .TICK_DIV(1)) dut1 (
        .clk  (clk),
        .rstn (rstn),
        .bus  (if1)
    );

    bcd_down_timer #(.N_DIGITS(2), .TICK_DIV(4)) dut4 (
        .clk  (clk),
        .rstn (rstn),
        .bus  (if4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    initial begin
        if1.clear = 0; if1.load = 0; if1.load_val = '0; if1.start = 0; if1.pause = 0;
        if4.clear = 0; if4.load = 0; if4.load_val = '0; if4.start = 0; if4.pause = 0;

        // Reset values
        step();
        check("rst_cnt", if1.cnt, 8'h00);
        check("rst_busy", if1.busy, 1'b0);
        check("rst_paused", if1.paused, 1'b0);
        check("rst_done", if1.done, 1'b0);
        check("rst_zero", if1.zero, 1'b1);
        rstn = 1;

        // Asynchronous reset mid-run
        if1.load = 1; if1.load_val = 8'h25;
        step();
        if1.load = 0;
        check("ld25_cnt", if1.cnt, 8'h25);
        check("ld25_busy", if1.busy, 1'b0);
        if1.start = 1;
        step();
        if1.start = 0;
        check("run_busy", if1.busy, 1'b1);
        step();
        check("run_first_dec", if1.cnt, 8'h24);
        #3 rstn = 0;
        #1;
        check("async_rst_cnt", if1.cnt, 8'h00);
        check("async_rst_busy", if1.busy, 1'b0);
        check("async_rst_done", if1.done, 1'b0);
        #1 rstn = 1;

        // Basic countdown from 25 with TICK_DIV=1
        step();
        if1.load = 1; if1.load_val = 8'h25;
        step();
        if1.load = 0; if1.start = 1;
        step();
        if1.start = 0;
        check("cd_entry_cnt", if1.cnt, 8'h25);
        check("cd_entry_busy", if1.busy, 1'b1);
        for (int i = 1; i <= 25; i++) begin
            step();
            check($sformatf("cd_cnt_%0d", i), if1.cnt, to_bcd(25 - i));
            check($sformatf("cd_done_%0d", i), if1.done, (i == 25) ? 1'b1 : 1'b0);
        end
        check("cd_end_busy", if1.busy, 1'b0);
        check("cd_end_zero", if1.zero, 1'b1);
        step();
        check("cd_done_pulse_end", if1.done, 1'b0);
        check("cd_hold_cnt", if1.cnt, 8'h00);
        if1.start = 1;
        step();
        if1.start = 0;
        check("done_start_ignored_done", if1.done, 1'b0);
        check("done_start_ignored_busy", if1.busy, 1'b0);

        // Pause/resume with TICK_DIV=4
        if4.load = 1; if4.load_val = 8'h03;
        step();
        if4.load = 0; if4.start = 1;
        step();
        if4.start = 0;
        check("p_run_busy", if4.busy, 1'b1);
        step();
        step();
        check("p_before_pause_cnt", if4.cnt, 8'h03);
        if4.pause = 1;
        step();
        if4.pause = 0;
        check("p_paused", if4.paused, 1'b1);
        check("p_busy_low", if4.busy, 1'b0);
        repeat (10) step();
        check("p_hold_cnt", if4.cnt, 8'h03);
        check("p_hold_paused", if4.paused, 1'b1);
        if4.start = 1;
        step();
        if4.start = 0;
        check("p_resume_busy", if4.busy, 1'b1);
        check("p_resume_cnt", if4.cnt, 8'h03);
        step();
        check("p_resume_cnt1", if4.cnt, 8'h03);
        step();
        check("p_resume_dec", if4.cnt, 8'h02);

        // Saturating load and clear mid-run
        if1.load = 1; if1.load_val = 8'hA3;
        step();
        if1.load = 0;
        check("sat_cnt", if1.cnt, 8'h93);
        if1.start = 1;
        step();
        if1.start = 0;
        step(); step(); step();
        check("sat_run_cnt", if1.cnt, 8'h90);
        if1.clear = 1;
        step();
        if1.clear = 0;
        check("clr_cnt", if1.cnt, 8'h00);
        check("clr_busy", if1.busy, 1'b0);
        check("clr_done", if1.done, 1'b0);
        step();
        check("clr_done_after", if1.done, 1'b0);

        // Start at zero
        if1.load = 1; if1.load_val = 8'h00;
        step();
        if1.load = 0; if1.start = 1;
        step();
        if1.start = 0;
        check("z_done", if1.done, 1'b1);
        check("z_busy", if1.busy, 1'b0);
        step();
        check("z_done_end", if1.done, 1'b0);
        if1.start = 1;
        step();
        if1.start = 0;
        check("z_restart_done", if1.done, 1'b0);

        // Priority
        if1.load = 1; if1.load_val = 8'h50; if1.start = 1; if1.clear = 1;
        step();
        if1.load = 0; if1.start = 0; if1.clear = 0;
        check("pri_clr_cnt", if1.cnt, 8'h00);
        check("pri_clr_busy", if1.busy, 1'b0);
        if1.load = 1; if1.load_val = 8'h50; if1.start = 1;
        step();
        if1.load = 0; if1.start = 0;
        check("pri_ld_cnt", if1.cnt, 8'h50);
        check("pri_ld_busy", if1.busy, 1'b0);
        step();
        check("pri_ld_hold", if1.cnt, 8'h50);
        if1.start = 1;
        step();
        if1.start = 0;
        check("pri_then_run", if1.busy, 1'b1);
        step();
        check("pri_run_dec", if1.cnt, 8'h49);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
